// File: rtl/pkt_sched_pkg.sv
// Shared types and helpers for the packet TX scheduler.
package pkt_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } pkt_sched_state_e;

  localparam int DEF_MAX_CREDITS = 8;

  function automatic int cnt_w(input int max_credits);
    return $clog2(max_credits + 1);
  endfunction

endpackage

// File: rtl/pkt_rr_arb.sv
// Combinational round-robin pick: first set request searching upward from ptr+1, wrapping.
module pkt_rr_arb #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt_oh,
  output logic [IDX_W-1:0]   gnt_idx
);

  always_comb begin
    logic found;
    int   idx;
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found       = 1'b1;
        gnt_oh[idx] = 1'b1;
        gnt_idx     = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/pkt_tx_sched.sv
// Credit-gated round-robin packet TX scheduler; grant held for a whole packet.
// Optional registered even parity on bus_tx when PKT_TX_SCHED_PARITY_EN is defined.
//
// state | meaning
// IDLE  | arbitrating; no source ready
// XFER  | grantee owns the bus until its last beat is accepted
module pkt_tx_sched
  import pkt_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 32,
  parameter int MAX_CREDITS = DEF_MAX_CREDITS,
  localparam int IDX_W = $clog2(NUM_REQ),
  localparam int CNT_W = cnt_w(MAX_CREDITS)
) (
  input  logic                      pkt_clk,
  input  logic                      pkt_rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      credit,
  output logic [DATA_W-1:0]         bus_tx,
  output logic                      bus_tx_valid,
  output logic                      bus_tx_last,
  output logic                      bus_tx_par,
  output logic [IDX_W-1:0]          grant_id,
  output logic [CNT_W-1:0]          credit_avail,
  output logic                      credit_ovf
);

  pkt_sched_state_e   state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [CNT_W-1:0]   credit_q, credit_d;
  logic               ovf_q, ovf_d;
  logic [DATA_W-1:0]  tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               tx_last_q, tx_last_d;
  logic [NUM_REQ-1:0] arb_oh;
  logic [IDX_W-1:0]   arb_idx;
  logic [DATA_W-1:0]  sel_data;
  logic               have_credit;
  logic               accept;

  pkt_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt_oh  (arb_oh),
    .gnt_idx (arb_idx)
  );

  assign have_credit = (credit_q != '0);
  assign sel_data    = req_data[int'(grant_q)*DATA_W +: DATA_W];
  assign accept      = (state_q == XFER) && have_credit && req_valid[grant_q];

  always_ff @(posedge pkt_clk) begin
    if (pkt_rst) begin
      state_q    <= IDLE;
      ptr_q      <= IDX_W'(NUM_REQ - 1);
      grant_q    <= '0;
      credit_q   <= CNT_W'(MAX_CREDITS);
      ovf_q      <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      credit_q   <= credit_d;
      ovf_q      <= ovf_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q  <= tx_last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    tx_valid_d = accept;
    tx_data_d  = tx_data_q;
    tx_last_d  = tx_last_q;
    credit_d   = credit_q;
    ovf_d      = ovf_q;
    case (state_q)
      IDLE: begin
        if ((|arb_oh) && have_credit) begin
          state_d = XFER;
          grant_d = arb_idx;
        end
      end
      XFER: begin
        if (accept && req_last[grant_q]) begin
          state_d = IDLE;
          ptr_d   = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      tx_data_d = sel_data;
      tx_last_d = req_last[grant_q];
    end
    // a credit and a debit in the same cycle cancel, even at full count
    if (credit && !accept) begin
      if (credit_q == CNT_W'(MAX_CREDITS)) ovf_d = 1'b1;
      else                                 credit_d = credit_q + CNT_W'(1);
    end else if (!credit && accept) begin
      credit_d = credit_q - CNT_W'(1);
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == XFER && have_credit) req_ready[grant_q] = 1'b1;
  end

`ifdef PKT_TX_SCHED_PARITY_EN
  logic par_q, par_d;

  always_comb begin
    par_d = par_q;
    if (accept) par_d = ^sel_data;
  end

  always_ff @(posedge pkt_clk) begin
    if (pkt_rst) par_q <= 1'b0;
    else         par_q <= par_d;
  end

  assign bus_tx_par = par_q;
`else
  assign bus_tx_par = 1'b0;
`endif

  assign bus_tx       = tx_data_q;
  assign bus_tx_valid = tx_valid_q;
  assign bus_tx_last  = tx_last_q;
  assign grant_id     = grant_q;
  assign credit_avail = credit_q;
  assign credit_ovf   = ovf_q;

endmodule

// File: tb/tb_pkt_tx_sched.sv
// Directed plus randomized bench for pkt_tx_sched against a transaction-level reference model.
module tb_pkt_tx_sched;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int MC = 8;
`ifdef PKT_TX_SCHED_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic              pkt_clk;
  logic              pkt_rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_last;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              credit;
  logic [DW-1:0]     bus_tx;
  logic              bus_tx_valid;
  logic              bus_tx_last;
  logic              bus_tx_par;
  logic [1:0]        grant_id;
  logic [3:0]        credit_avail;
  logic              credit_ovf;

  pkt_tx_sched #(.NUM_REQ(NR), .DATA_W(DW), .MAX_CREDITS(MC)) dut (
    .pkt_clk      (pkt_clk),
    .pkt_rst      (pkt_rst),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .credit       (credit),
    .bus_tx       (bus_tx),
    .bus_tx_valid (bus_tx_valid),
    .bus_tx_last  (bus_tx_last),
    .bus_tx_par   (bus_tx_par),
    .grant_id     (grant_id),
    .credit_avail (credit_avail),
    .credit_ovf   (credit_ovf)
  );

  initial pkt_clk = 1'b0;
  always #5 pkt_clk = ~pkt_clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // reference model: who owns the bus, whose turn is next, credit pool, last bus beat
  bit          m_busy;
  int          m_grant;
  int          m_ptr;
  int          m_cred;
  bit          m_ovf;
  bit          m_valid;
  bit          m_last;
  bit          m_par;
  bit          m_acc;
  logic [31:0] m_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_grant = 0;
    m_ptr   = NR - 1;
    m_cred  = MC;
    m_ovf   = 1'b0;
    m_valid = 1'b0;
    m_last  = 1'b0;
    m_par   = 1'b0;
    m_acc   = 1'b0;
    m_data  = '0;
  endtask

  task automatic chk_outs();
    chk("bus_tx_valid", 64'(bus_tx_valid), 64'(m_valid));
    chk("bus_tx",       64'(bus_tx),       64'(m_data));
    chk("bus_tx_last",  64'(bus_tx_last),  64'(m_last));
    chk("bus_tx_par",   64'(bus_tx_par),   64'(m_par));
    chk("grant_id",     64'(grant_id),     64'(m_grant));
    chk("credit_avail", 64'(credit_avail), 64'(m_cred));
    chk("credit_ovf",   64'(credit_ovf),   64'(m_ovf));
  endtask

  task automatic do_reset();
    pkt_rst = 1'b1;
    @(posedge pkt_clk);
    #1;
    pkt_rst = 1'b0;
    model_reset();
    chk("rst_valid",  64'(bus_tx_valid), 64'(0));
    chk("rst_data",   64'(bus_tx),       64'(0));
    chk("rst_last",   64'(bus_tx_last),  64'(0));
    chk("rst_par",    64'(bus_tx_par),   64'(0));
    chk("rst_grant",  64'(grant_id),     64'(0));
    chk("rst_credit", 64'(credit_avail), 64'(MC));
    chk("rst_ovf",    64'(credit_ovf),   64'(0));
    chk("rst_ready",  64'(req_ready),    64'(0));
  endtask

  // one clock: apply inputs, check ready, advance the model, check registered outputs
  task automatic cycle_go(input logic [NR-1:0] rv, input logic [NR-1:0] rl,
                          input logic [NR*DW-1:0] rd, input logic cr);
    logic [NR-1:0] exp_rdy;
    bit            found;
    int            idx;
    req_valid = rv;
    req_last  = rl;
    req_data  = rd;
    credit    = cr;
    #1;
    exp_rdy = '0;
    if (m_busy && m_cred > 0) exp_rdy[m_grant] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    m_acc = m_busy && (m_cred > 0) && rv[m_grant];
    if (!m_busy) begin
      found = 1'b0;
      if (rv != '0 && m_cred > 0) begin
        for (int k = 1; k <= NR; k++) begin
          idx = (m_ptr + k) % NR;
          if (!found && rv[idx]) begin
            found   = 1'b1;
            m_grant = idx;
          end
        end
        m_busy = 1'b1;
      end
    end else if (m_acc) begin
      m_data = rd[m_grant*DW +: DW];
      m_last = rl[m_grant];
      m_par  = PAR_ON ? ^m_data : 1'b0;
      if (rl[m_grant]) begin
        m_ptr  = m_grant;
        m_busy = 1'b0;
      end
    end
    m_valid = m_acc;
    m_cred  = m_cred + int'(cr) - int'(m_acc);
    if (m_cred > MC) begin
      m_cred = MC;
      m_ovf  = 1'b1;
    end
    @(posedge pkt_clk);
    #1;
    chk_outs();
  endtask

  // present beats b0..b1-1 of an n-beat packet from src; crmode 1 = credit while owning, 2 = credit on last beat
  task automatic send_beats(input int src, input int b0, input int b1, input int n,
                            input logic [31:0] base, input int crmode);
    int               b;
    int               budget;
    logic [NR*DW-1:0] rd;
    logic [NR-1:0]    rv;
    logic [NR-1:0]    rl;
    logic             cr;
    b      = b0;
    budget = 0;
    while (b < b1 && budget < 64) begin
      rd = '0;
      rd[src*DW +: DW] = base + 32'(b);
      rv = '0;
      rv[src] = 1'b1;
      rl = '0;
      rl[src] = (b == n - 1);
      cr = ((crmode == 1) && m_busy) || ((crmode == 2) && m_busy && (b == n - 1));
      cycle_go(rv, rl, rd, cr);
      if (m_acc) b++;
      budget++;
    end
    chk("send_done", 64'(b), 64'(b1));
  endtask

  initial begin
    int               order[$];
    logic [NR*DW-1:0] rd;
    logic [NR-1:0]    rv;
    logic [NR-1:0]    rl;

    pkt_rst   = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    credit    = 1'b0;
    model_reset();
    do_reset();

    // single source, three beats
    send_beats(0, 0, 3, 3, 32'hA000_0001, 0);
    chk("single_last",   64'(bus_tx_last),  64'(1));
    chk("single_data",   64'(bus_tx),       64'hA000_0003);
    chk("single_credit", 64'(credit_avail), 64'(5));
    chk("single_grant",  64'(grant_id),     64'(0));
    cycle_go('0, '0, '0, 1'b0);
    chk("single_idle",   64'(bus_tx_valid), 64'(0));

    // fairness with 1-beat packets from every source
    do_reset();
    rd = '0;
    for (int i = 0; i < NR; i++) rd[i*DW +: DW] = 32'h100 + 32'(i);
    for (int c = 0; c < 20; c++) begin
      cycle_go('1, '1, rd, 1'b1);
      if (m_acc) order.push_back(int'(grant_id));
    end
    chk("fair_count", 64'(order.size() >= 8), 64'(1));
    for (int i = 0; i < 8 && i < order.size(); i++) chk("fair_order", 64'(order[i]), 64'(i % NR));

    // credit stall: drain to 2, then a 4-beat packet from req1
    do_reset();
    send_beats(0, 0, 6, 6, 32'hB000_0000, 0);
    chk("stall_pre", 64'(credit_avail), 64'(2));
    send_beats(1, 0, 2, 4, 32'hC000_0000, 0);
    rd = '0;
    rd[1*DW +: DW] = 32'hC000_0002;
    for (int c = 0; c < 3; c++) cycle_go(4'b0010, 4'b0000, rd, 1'b0);
    chk("stall_ready", 64'(req_ready),    64'(0));
    chk("stall_grant", 64'(grant_id),     64'(1));
    chk("stall_cred",  64'(credit_avail), 64'(0));
    cycle_go(4'b0010, 4'b0000, rd, 1'b1);
    chk("stall_T_valid", 64'(bus_tx_valid), 64'(0));
    cycle_go(4'b0010, 4'b0000, rd, 1'b0);
    chk("stall_T1_valid", 64'(bus_tx_valid), 64'(1));
    chk("stall_T1_data",  64'(bus_tx),       64'hC000_0002);
    send_beats(1, 3, 4, 4, 32'hC000_0000, 1);
    chk("stall_last", 64'(bus_tx_last), 64'(1));

    // credit and debit together at 3
    do_reset();
    send_beats(0, 0, 6, 6, 32'hD000_0000, 2);
    chk("simul_3", 64'(credit_avail), 64'(3));

    // credit and debit together at full count, then a bare credit at full count
    do_reset();
    send_beats(1, 0, 2, 2, 32'hE000_0000, 1);
    chk("simul_full_cred", 64'(credit_avail), 64'(MC));
    chk("simul_full_ovf",  64'(credit_ovf),   64'(0));
    cycle_go('0, '0, '0, 1'b1);
    chk("ovf_set",  64'(credit_ovf),   64'(1));
    chk("ovf_cred", 64'(credit_avail), 64'(MC));
    send_beats(2, 0, 2, 2, 32'hE100_0000, 0);
    chk("ovf_sticky", 64'(credit_ovf), 64'(1));

    // reset in the middle of a packet from req2
    do_reset();
    send_beats(2, 0, 2, 4, 32'hF000_0000, 0);
    chk("mid_cred", 64'(credit_avail), 64'(6));
    do_reset();
    rd = '0;
    rd[0*DW +: DW] = 32'h5555_0000;
    rd[2*DW +: DW] = 32'h5555_0002;
    cycle_go(4'b0101, 4'b0101, rd, 1'b0);
    chk("mid_prio", 64'(grant_id), 64'(0));
    cycle_go(4'b0101, 4'b0101, rd, 1'b0);
    chk("mid_data", 64'(bus_tx), 64'h5555_0000);

    // parity
    send_beats(3, 0, 1, 1, 32'h0000_0007, 0);
    chk("par_7", 64'(bus_tx_par), 64'(PAR_ON));
    send_beats(3, 0, 1, 1, 32'h0000_0003, 0);
    chk("par_3", 64'(bus_tx_par), 64'(0));

    // randomized traffic
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rv = NR'($urandom_range(0, (1 << NR) - 1));
      rl = '0;
      for (int i = 0; i < NR; i++) rl[i] = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < NR; i++) rd[i*DW +: DW] = $urandom;
      cycle_go(rv, rl, rd, 1'($urandom_range(0, 1)));
      if (c == 200) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
